// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences one WIDTH-bit add/sub through an external 4-bit adder slice, LSB nibble first.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             op_sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic [3:0]       add_a_o,
  output logic [3:0]       add_b_o,
  output logic             add_cin_o,
  input  logic [3:0]       add_sum_i,
  input  logic             add_cout_i
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, carry_out_q, overflow_q, in_ready_q, out_valid_q;
  logic             run, last;
  assign run         = state_q == RUN;
  assign last        = idx_q == IW'(NIB - 1);
  assign add_a_o     = run ? a_q[idx_q*4 +: 4] : 4'h0;
  assign add_b_o     = run ? b_q[idx_q*4 +: 4] : 4'h0;
  assign add_cin_o   = run & carry_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          a_q        <= op_a_i;
          b_q        <= op_sub_i ? ~op_b_i : op_b_i;
          carry_q    <= op_sub_i;
          idx_q      <= '0;
          result_q   <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          result_q[idx_q*4 +: 4] <= add_sum_i;
          carry_q                <= add_cout_i;
          idx_q                  <= idx_q + 1'b1;
          if (last) begin
            carry_out_q <= add_cout_i;
            overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (add_sum_i[3] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed checks of the nibble-serial add/sub sequencer with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, op_sub = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, result;
  logic        out_valid, out_ready = 1'b1, carry_out, overflow;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  int          errors = 0, checks = 0;
  logic [15:0] r_res;
  logic        r_co, r_ov;
  int          r_cyc;
  logic [3:0]  r_cin, r_b0;

  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_a_i(op_a), .op_b_i(op_b), .op_sub_i(op_sub), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .carry_out_o(carry_out), .overflow_o(overflow),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin), .add_sum_i(add_sum), .add_cout_i(add_cout)
  );

  // Accepts one operation (DUT assumed idle) and waits for out_valid; r_cyc counts edges including the accept edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_cyc = 1; r_cin = '0; r_b0 = add_b;
    while (!out_valid && r_cyc < 20) begin
      if (r_cyc <= 4) r_cin[r_cyc-1] = add_cin;
      @(posedge clk); #1;
      r_cyc++;
    end
    r_res = result; r_co = carry_out; r_ov = overflow;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h co=%b ov=%b required 1 0 0000 0 0", in_ready, out_valid, result, carry_out, overflow);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 9'h0) begin
      errors++;
      $display("FAIL reset_adder: got %h required 000", {add_a, add_b, add_cin});
    end
  endtask

  task automatic test_add;
    run_op(16'h1234, 16'h0FCD, 1'b0);
    checks++;
    if (r_res !== 16'h2201 || r_co !== 1'b0 || r_ov !== 1'b0) begin
      errors++;
      $display("FAIL add_basic: result=%h co=%b ov=%b required 2201 0 0", r_res, r_co, r_ov);
    end
    checks++;
    if (r_cyc !== 5) begin
      errors++;
      $display("FAIL add_latency: got %0d required 5", r_cyc);
    end
    checks++;
    if (r_cin !== 4'b1110) begin
      errors++;
      $display("FAIL add_cin_seq: got %b required 1110 (msb=k3)", r_cin);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    run_op(16'h8000, 16'h8000, 1'b0);
    checks++;
    if (r_res !== 16'h0000 || r_co !== 1'b1 || r_ov !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: result=%h co=%b ov=%b required 0000 1 1", r_res, r_co, r_ov);
    end
    @(posedge clk); #1;
    run_op(16'h7FFF, 16'h0001, 1'b0);
    checks++;
    if (r_res !== 16'h8000 || r_co !== 1'b0 || r_ov !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos: result=%h co=%b ov=%b required 8000 0 1", r_res, r_co, r_ov);
    end
    checks++;
    if (r_cin !== 4'b1110) begin
      errors++;
      $display("FAIL ovf_pos_cin_seq: got %b required 1110", r_cin);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    run_op(16'h0005, 16'h0007, 1'b1);
    checks++;
    if (r_res !== 16'hFFFE || r_co !== 1'b0 || r_ov !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: result=%h co=%b ov=%b required fffe 0 0", r_res, r_co, r_ov);
    end
    checks++;
    if (r_cin[0] !== 1'b1 || r_b0 !== 4'h8) begin
      errors++;
      $display("FAIL sub_first_nibble: cin=%b add_b=%h required 1 8", r_cin[0], r_b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic stable_ok = 1'b1;
    int   n;
    out_ready = 1'b0;
    run_op(16'h1111, 16'h2222, 1'b0);
    checks++;
    if (r_res !== 16'h3333) begin
      errors++;
      $display("FAIL bp_first: result=%h required 3333", r_res);
    end
    op_a = 16'h0100; op_b = 16'h0001; op_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== 16'h3333 || in_ready !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL bp_hold: result=%h in_ready=%b out_valid=%b required 3333 0 1", result, in_ready, out_valid);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: in_ready=%b required 0", in_ready);
    end
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (result !== 16'h0101 || n !== 5) begin
      errors++;
      $display("FAIL bp_second_result: result=%h cycles=%0d required 0101 5", result, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic saw_valid = 1'b0;
    op_a = 16'h1234; op_b = 16'h4321; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b1 || add_cin !== 1'b0 || add_a !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_run: out_valid=%b result=%h in_ready=%b cin=%b add_a=%h required 0 0000 1 0 0", out_valid, result, in_ready, add_cin, add_a);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (saw_valid || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: out_valid seen=%b required 0", saw_valid | out_valid);
    end
    run_op(16'hFFFF, 16'h0001, 1'b0);
    checks++;
    if (r_res !== 16'h0000 || r_co !== 1'b1 || r_ov !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_op: result=%h co=%b ov=%b required 0000 1 0", r_res, r_co, r_ov);
    end
  endtask

  initial begin
    #12;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add;
    test_overflow;
    test_sub;
    test_back_to_back;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs one WIDTH-bit add or subtract using a single external 4-bit ripple adder slice.
- Processes one nibble per cycle, LSB nibble first, and chains the carry through an internal register.
- Sits between a requester (valid/ready operand interface) and one 4-bit full-adder instance, so wide arithmetic reuses one small datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, nibble count (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  final carry out of the MSB nibble (for subtract: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.
- add_a  output  4  nibble to adder A input.
- add_b  output  4  nibble to adder B input (already inverted for subtract).
- add_cin  output  1  adder carry-in.
- add_sum  input  4  adder sum (combinational from add_a, add_b, add_cin).
- add_cout  input  1  adder carry out.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n). The clock is clk.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result, carry_out, overflow = 0.
  - add_a, add_b, add_cin = 0; nibble index = 0; carry register = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register op_a into a_reg and b_eff = op_sub ? ~op_b : op_b.
  - Set carry register = op_sub; clear index and the result register; go to RUN.
- RUN, cycle k (k = 0..NIB-1):
  - Adder drive: add_a = a_reg[4k+3:4k], add_b = b_eff[4k+3:4k], add_cin = carry register.
  - At the clock edge: result[4k+3:4k] <= add_sum; carry register <= add_cout; index increments.
  - After k = NIB-1: carry_out <= add_cout; overflow <= (a_reg[W-1] == b_eff[W-1]) & (add_sum[3] != a_reg[W-1]); go to DONE.
  - in_ready = 0 throughout RUN.
- Adder outputs are 0 whenever the state is not RUN, so no activity leaks to the slice.
- DONE:
  - out_valid = 1.
  - result, carry_out and overflow are stable until the handshake.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - No operand accept in the same cycle (in_ready = 0 in DONE).
- Latency:
  - Accept edge to out_valid high = NIB+1 clock edges (NIB run cycles plus the DONE entry).
  - With WIDTH=16: 4 run cycles, and out_valid is first seen in the 5th cycle after accept.
  - Throughput: one operation per NIB+2 cycles with out_ready held high.
- Boundary conditions:
  - in_valid during RUN/DONE: ignored; the requester must hold it until in_ready.
  - out_ready asserted early (before DONE): no effect.
  - Index wraps only through the IDLE clear, never mid-operation.
  - rst_n asserted mid-RUN or in DONE: immediate return to reset values; the partial result is discarded and out_valid never pulses.
  - WIDTH=4: a single RUN cycle; overflow and carry come from that nibble.

Test Plan:
- Add, no overflow: WIDTH=16, A=0x1234, B=0x0FCD, sub=0.
  - Required: result=0x2201, carry_out=0, overflow=0.
  - out_valid rises exactly 5 cycles after accept.
  - add_cin sequence 0,1,1,1 (carry ripples from every nibble).
- Add, signed overflow with carry: A=0x8000, B=0x8000, sub=0.
  - Required: result=0x0000, carry_out=1, overflow=1.
- Add, positive overflow: A=0x7FFF, B=0x0001.
  - Required: result=0x8000, carry_out=0, overflow=1, add_cin sequence 0,1,1,1.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1.
  - Required: result=0xFFFE, carry_out=0, overflow=0, first add_cin=1, add_b first nibble=0x8.
- Backpressure and early request: hold out_ready=0 for 10 cycles in DONE.
  - Required: result stable, in_ready=0 throughout; a second in_valid is not accepted until the cycle after the out_ready handshake.
- Reset during RUN: assert rst_n=0 at run cycle 2.
  - Required: out_valid=0, result=0, in_ready=1 immediately after reset.
  - The next operation, 0xFFFF+0x0001, gives result=0x0000, carry_out=1, overflow=0.
